// File: rtl/emesh_txn_buffer.sv
// Transaction FIFO in front of the AXI/eLink arbiter. It absorbs wr_wait/rd_wait
// backpressure and re-presents emesh transactions in order from a registered head.
module emesh_txn_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                         eclk,
  input  logic                         reset,
  // upstream transaction
  input  logic                         access_in,
  input  logic                         write_in,
  input  logic [1:0]                   datamode_in,
  input  logic [3:0]                   ctrlmode_in,
  input  logic [AW-1:0]                dstaddr_in,
  input  logic [AW-1:0]                srcaddr_in,
  input  logic [AW-1:0]                data_in,
  output logic                         wr_wait_out,
  output logic                         rd_wait_out,
  // downstream head entry
  output logic                         access_out,
  output logic                         write_out,
  output logic [1:0]                   datamode_out,
  output logic [3:0]                   ctrlmode_out,
  output logic [AW-1:0]                dstaddr_out,
  output logic [AW-1:0]                srcaddr_out,
  output logic [AW-1:0]                data_out,
  input  logic                         wr_wait_in,
  input  logic                         rd_wait_in,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic          write;
    logic [1:0]    datamode;
    logic [3:0]    ctrlmode;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [AW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  entry_t          next_head;
  logic            head_load;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_inc;
  logic [CW-1:0]   count_next;

  logic            full;
  logic            empty;
  logic            head_wait;
  logic            pop;
  logic            push;
  logic            drop;
  logic            wait_next;

  assign in_entry = '{write:    write_in,
                      datamode: datamode_in,
                      ctrlmode: ctrlmode_in,
                      dstaddr:  dstaddr_in,
                      srcaddr:  srcaddr_in,
                      data:     data_in};

  assign full       = (fifo_count == CW'(DEPTH));
  assign empty      = (fifo_count == '0);
  assign rd_ptr_inc = rd_ptr + PW'(1);

  // The head's own type selects which downstream stall applies, so a stalled
  // read blocks everything queued behind it.
  assign head_wait = head.write ? wr_wait_in : rd_wait_in;
  assign pop       = access_out && !head_wait;
  assign push      = access_in && (!full || pop);
  assign drop      = access_in && full && !pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = fifo_count;
    unique case ({push, pop})
      2'b10:   count_next = fifo_count + CW'(1);
      2'b01:   count_next = fifo_count - CW'(1);
      default: count_next = fifo_count;
    endcase
  end

  // Wait rises one entry early so an access already in flight still fits.
  assign wait_next = (count_next >= CW'(DEPTH-1));

  // The next head comes from storage, except when the entry being pushed this
  // cycle is itself the new head and is not yet readable from memory.
  always_comb begin
    head_load = 1'b0;
    next_head = head;
    if (pop) begin
      if (fifo_count == CW'(1)) begin
        if (push) begin
          head_load = 1'b1;
          next_head = in_entry;
        end
      end else begin
        head_load = 1'b1;
        next_head = mem[rd_ptr_inc];
      end
    end else if (push && empty) begin
      head_load = 1'b1;
      next_head = in_entry;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked entirely by the
  // pointers and count, so stale contents are never presented.
  always_ff @(posedge eclk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      access_out  <= 1'b0;
      wr_wait_out <= 1'b0;
      rd_wait_out <= 1'b0;
      overflow    <= 1'b0;
      head        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      fifo_count  <= count_next;
      access_out  <= (count_next != '0);
      wr_wait_out <= wait_next;
      rd_wait_out <= wait_next;
      if (drop)      overflow <= 1'b1;
      if (head_load) head     <= next_head;
    end
  end

  assign write_out    = head.write;
  assign datamode_out = head.datamode;
  assign ctrlmode_out = head.ctrlmode;
  assign dstaddr_out  = head.dstaddr;
  assign srcaddr_out  = head.srcaddr;
  assign data_out     = head.data;

endmodule
